// File: rtl/xc_aesmix.sv
// AES MixColumns / InvMixColumns unit: one output byte per cycle from a single
// shared GF(2^8) byte combiner, result zero-masked outside the completion cycle.
module xc_aesmix (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        enc,
  output logic        ready,
  output logic [31:0] result
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] col_q, col_d;
  logic [31:0] acc_q, acc_d;
  logic        enc_q, enc_d;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Per-byte xtime chains: x1 = 2a, x2 = 4a, x3 = 8a
  logic [3:0][7:0] c, x1, x2, x3;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chain
      assign c[gi]  = col_q[8*gi +: 8];
      assign x1[gi] = xtime(c[gi]);
      assign x2[gi] = xtime(x1[gi]);
      assign x3[gi] = xtime(x2[gi]);
    end
  endgenerate

  logic [7:0] fwd_b, inv_b, mix_b;

  assign fwd_b = x1[0] ^ (x1[1] ^ c[1]) ^ c[2] ^ c[3];
  assign inv_b = (x3[0] ^ x2[0] ^ x1[0])
               ^ (x3[1] ^ x1[1] ^ c[1])
               ^ (x3[2] ^ x2[2] ^ c[2])
               ^ (x3[3] ^ c[3]);
  assign mix_b = enc_q ? fwd_b : inv_b;

  // Only a0,a1 come from rs1 and a2,a3 from rs2
  logic unused_bits;
  assign unused_bits = ^{rs1[31:16], rs2[15:0]};

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    acc_d   = acc_q;
    enc_d   = enc_q;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          col_d   = {rs2[31:16], rs1[15:0]};
          enc_d   = enc;
          acc_d   = 32'h0;
          state_d = S0;
        end
      end
      S0, S1, S2, S3: begin
        if (!valid) begin
          state_d = IDLE;
        end else begin
          acc_d = {mix_b, acc_q[31:8]};
          col_d = {col_q[7:0], col_q[31:8]};
          unique case (state_q)
            S0:      state_d = S1;
            S1:      state_d = S2;
            S2:      state_d = S3;
            default: state_d = DONE;
          endcase
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= 32'h0;
      acc_q   <= 32'h0;
      enc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      enc_q   <= enc_d;
    end
  end

  assign ready  = (state_q == DONE);
  assign result = ready ? acc_q : 32'h0;

endmodule

// File: tb/tb_xc_aesmix.sv
// Randomised and directed checks of xc_aesmix against a generic GF(2^8)
// matrix-multiply model of MixColumns / InvMixColumns.
module tb_xc_aesmix;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] rs1   = 32'h0;
  logic [31:0] rs2   = 32'h0;
  logic        enc   = 1'b0;
  logic        ready;
  logic [31:0] result;

  int vecs = 0;
  int errs = 0;

  xc_aesmix dut (
    .clock  (clock),
    .reset  (reset),
    .valid  (valid),
    .rs1    (rs1),
    .rs2    (rs2),
    .enc    (enc),
    .ready  (ready),
    .result (result)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Generic shift-and-add GF(2^8) multiply, modulus 0x11b
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Circulant matrix times column; col = {a3,a2,a1,a0}
  function automatic logic [31:0] mix_ref(input logic [31:0] col, input logic e);
    logic [7:0] a [4];
    logic [7:0] k [4];
    logic [31:0] r = 32'h0;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) a[i] = col[8*i +: 8];
    if (e) begin
      k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
    end else begin
      k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
    end
    for (int i = 0; i < 4; i++) begin
      b = 8'h0;
      for (int j = 0; j < 4; j++) b = b ^ gmul(k[j], a[(i + j) % 4]);
      r[8*i +: 8] = b;
    end
    return r;
  endfunction

  // Issue one request, wait for ready, drop valid; scramble changes operands
  // every cycle after acceptance.
  task automatic req(input logic [31:0] col, input logic e, input bit scramble,
                     output logic [31:0] res, output int lat);
    logic [31:0] junk;
    bit leak = 0;
    @(negedge clock);
    junk  = $urandom;
    rs1   = {junk[31:16], col[15:0]};
    rs2   = {col[31:16], junk[15:0]};
    enc   = e;
    valid = 1'b1;
    lat   = 0;
    res   = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (ready) begin
        res = result;
        lat = k;
        break;
      end
      if (result !== 32'h0) leak = 1;
      if (scramble) begin
        rs1 = $urandom;
        rs2 = $urandom;
        enc = 1'($urandom);
      end
    end
    valid = 1'b0;
    vecs++;
    if (leak) begin
      errs++;
      $display("FAIL result_mask: got nonzero result before ready, required 00000000");
    end
    @(negedge clock);
    vecs++;
    if (ready !== 1'b0) begin
      errs++;
      $display("FAIL ready_pulse: got ready=%b one cycle after completion, required 0", ready);
    end
  endtask

  task automatic test_reset;
    valid = 1'b1;
    rs1   = $urandom;
    rs2   = $urandom;
    enc   = 1'b1;
    repeat (3) @(negedge clock);
    vecs++;
    if (ready !== 1'b0 || result !== 32'h0) begin
      errs++;
      $display("FAIL reset_state: got ready=%b result=%h, required ready=0 result=00000000", ready, result);
    end
    $display("reset: ready=%b result=%h", ready, result);
    valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_vectors;
    logic [31:0] cols [7] = '{32'h4553_13db, 32'hbca1_4d8e, 32'h5c22_0af2, 32'h0101_0101,
                              32'h0101_0101, 32'hc6c6_c6c6, 32'hc6c6_c6c6};
    logic        modes [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] exps [7] = '{32'hbca1_4d8e, 32'h4553_13db, 32'h9d58_dc9f, 32'h0101_0101,
                              32'h0101_0101, 32'hc6c6_c6c6, 32'hc6c6_c6c6};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 7; i++) begin
      req(cols[i], modes[i], 0, res, lat);
      $display("vector %0d: col=%h enc=%0d result=%h latency=%0d", i, cols[i], modes[i], res, lat);
      vecs++;
      if (res !== exps[i]) begin
        errs++;
        $display("FAIL vector_%0d: got %h required %h", i, res, exps[i]);
      end
      vecs++;
      if (lat != 5) begin
        errs++;
        $display("FAIL latency_%0d: got %0d required 5", i, lat);
      end
    end
  endtask

  task automatic test_operand_change;
    logic [31:0] col, res, exp;
    logic e;
    int lat;
    for (int i = 0; i < 4; i++) begin
      col = $urandom;
      e   = 1'(i);
      exp = mix_ref(col, e);
      req(col, e, 1, res, lat);
      $display("operand_change: col=%h enc=%0d result=%h", col, e, res);
      vecs++;
      if (res !== exp || lat != 5) begin
        errs++;
        $display("FAIL operand_change: got %h lat %0d required %h lat 5", res, lat, exp);
      end
    end
  endtask

  task automatic test_abort;
    logic [31:0] col, res, exp;
    int lat;
    bit seen = 0;
    @(negedge clock);
    rs1   = 32'h0000_13db;
    rs2   = 32'h4553_0000;
    enc   = 1'b1;
    valid = 1'b1;
    repeat (3) @(negedge clock);
    valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (ready !== 1'b0 || result !== 32'h0) seen = 1;
      @(negedge clock);
    end
    $display("abort: dropped valid in S2, ready seen=%0d", seen);
    vecs++;
    if (seen) begin
      errs++;
      $display("FAIL abort: got ready/result activity after abort, required none");
    end
    col = $urandom;
    exp = mix_ref(col, 1'b0);
    req(col, 1'b0, 0, res, lat);
    $display("after_abort: col=%h result=%h latency=%0d", col, res, lat);
    vecs++;
    if (res !== exp || lat != 5) begin
      errs++;
      $display("FAIL after_abort: got %h lat %0d required %h lat 5", res, lat, exp);
    end
  endtask

  task automatic test_reset_mid;
    bit seen = 0;
    bit hit  = 0;
    @(negedge clock);
    rs1   = 32'h0000_13db;
    rs2   = 32'h4553_0000;
    enc   = 1'b1;
    valid = 1'b1;
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    vecs++;
    if (ready !== 1'b0 || result !== 32'h0) begin
      errs++;
      $display("FAIL reset_s1: got ready=%b result=%h required 0/00000000", ready, result);
    end
    valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    // Reset asserted mid-cycle while in DONE must clear outputs at once
    valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (ready) begin
        hit = 1;
        break;
      end
    end
    #2 reset = 1'b1;
    #1;
    $display("reset_done: ready=%b result=%h", ready, result);
    vecs++;
    if (!hit || ready !== 1'b0 || result !== 32'h0) begin
      errs++;
      $display("FAIL reset_done: got reached=%0d ready=%b result=%h required reached=1 ready=0 result=00000000",
               hit, ready, result);
    end
    valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (ready !== 1'b0) seen = 1;
    end
    vecs++;
    if (seen) begin
      errs++;
      $display("FAIL reset_idle: got ready after reset release, required 0");
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] c1, c2, r1, r2;
    int t1 = 0;
    int t2 = 0;
    c1 = $urandom;
    c2 = $urandom;
    @(negedge clock);
    rs1   = {16'h0, c1[15:0]};
    rs2   = {c1[31:16], 16'h0};
    enc   = 1'b1;
    valid = 1'b1;
    r1    = 32'h0;
    r2    = 32'h0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (ready) begin
        if (t1 == 0) begin
          t1 = k;
          r1 = result;
          rs1 = {16'h0, c2[15:0]};
          rs2 = {c2[31:16], 16'h0};
          enc = 1'b0;
        end else begin
          t2 = k;
          r2 = result;
          break;
        end
      end
    end
    valid = 1'b0;
    $display("back_to_back: r1=%h at %0d r2=%h at %0d", r1, t1, r2, t2);
    vecs++;
    if (r1 !== mix_ref(c1, 1'b1) || t1 != 5) begin
      errs++;
      $display("FAIL b2b_first: got %h at %0d required %h at 5", r1, t1, mix_ref(c1, 1'b1));
    end
    vecs++;
    if (r2 !== mix_ref(c2, 1'b0) || (t2 - t1) != 6) begin
      errs++;
      $display("FAIL b2b_second: got %h gap %0d required %h gap 6", r2, t2 - t1, mix_ref(c2, 1'b0));
    end
    @(negedge clock);
  endtask

  task automatic test_random;
    logic [31:0] col, res, back, exp;
    logic e;
    int lat;
    int bad = 0;
    for (int i = 0; i < 2500; i++) begin
      col = $urandom;
      req(col, 1'b1, 0, res, lat);
      req(res, 1'b0, 0, back, lat);
      vecs++;
      if (res !== mix_ref(col, 1'b1)) begin
        errs++; bad++;
        $display("FAIL random_fwd: col %h got %h required %h", col, res, mix_ref(col, 1'b1));
      end
      vecs++;
      if (back !== col) begin
        errs++; bad++;
        $display("FAIL random_roundtrip: got %h required %h", back, col);
      end
    end
    for (int i = 0; i < 1000; i++) begin
      col = $urandom;
      e   = 1'($urandom);
      exp = mix_ref(col, e);
      req(col, e, 0, res, lat);
      vecs++;
      if (res !== exp) begin
        errs++; bad++;
        $display("FAIL random_mode: col %h enc %0d got %h required %h", col, e, res, exp);
      end
    end
    $display("random: 6000 transactions, %0d bad", bad);
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_operand_change;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
